// File: rtl/wptr_full.sv
// wptr_full: write-side pointer and full-flag controller for a dual-clock FIFO.
// Keeps a binary/Gray write counter, exports the Gray pointer to the read
// domain and derives a registered full flag from the synchronized read pointer.
// Optional feature macro WPTR_LEVEL_EN: when defined, builds the Gray-to-binary
// converter, the fill level (wlevel) and the almost-full flag (walmost_full).
// When undefined, wlevel and walmost_full are tied to 0. All other outputs
// behave the same in both builds.
module wptr_full #(
  parameter int ASIZE        = 4,
  parameter int AFULL_THRESH = (1 << ASIZE) - 2
) (
  input  logic             wclk,
  input  logic             wrst_n,
  input  logic             winc,
  input  logic [ASIZE:0]   wq2_rptr,
  input  logic             wovf_clr,
  output logic [ASIZE-1:0] waddr,
  output logic [ASIZE:0]   wptr,
  output logic             wfull,
  output logic             walmost_full,
  output logic [ASIZE:0]   wlevel,
  output logic             woverflow
);

  // Binary write counter addresses the memory; Gray copy crosses domains.
  logic [ASIZE:0] wbin_reg;
  logic [ASIZE:0] wbin_next;
  logic [ASIZE:0] wgray_reg;
  logic [ASIZE:0] wgray_next;
  logic           wfull_reg;
  logic           wfull_next;
  logic           wovf_reg;
  logic           wovf_next;
  logic           wpush;
  logic [ASIZE:0] full_match;

  // Push is accepted only when the FIFO is not already full.
  assign wpush      = winc & ~wfull_reg;
  assign wbin_next  = wbin_reg + {{ASIZE{1'b0}}, wpush};
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // In Gray code "exactly one lap ahead" means the two MSBs are inverted
  // and the remaining bits match the read pointer.
  assign full_match = {~wq2_rptr[ASIZE:ASIZE-1], wq2_rptr[ASIZE-2:0]};
  assign wfull_next = (wgray_next == full_match);

  // A write attempted while full sets the sticky flag; a set wins over clear.
  assign wovf_next  = (winc & wfull_reg) | (wovf_reg & ~wovf_clr);

  // Pointer, full and overflow state registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wbin_reg  <= '0;
      wgray_reg <= '0;
      wfull_reg <= 1'b0;
      wovf_reg  <= 1'b0;
    end else begin
      wbin_reg  <= wbin_next;
      wgray_reg <= wgray_next;
      wfull_reg <= wfull_next;
      wovf_reg  <= wovf_next;
    end
  end

  assign waddr     = wbin_reg[ASIZE-1:0];
  assign wptr      = wgray_reg;
  assign wfull     = wfull_reg;
  assign woverflow = wovf_reg;

`ifdef WPTR_LEVEL_EN
  localparam logic [ASIZE:0] AFULL_LVL = AFULL_THRESH[ASIZE:0];

  logic [ASIZE:0] rbin;
  logic [ASIZE:0] level_next;
  logic           afull_next;
  logic [ASIZE:0] wlevel_reg;
  logic           afull_reg;

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  for (genvar gi = 0; gi <= ASIZE; gi++) begin : g_rbin
    assign rbin[gi] = ^wq2_rptr[ASIZE:gi];
  end

  // Level uses the post-push write pointer, so it is conservative only by
  // the synchronizer lag on the read side.
  assign level_next = wbin_next - rbin;
  assign afull_next = (level_next >= AFULL_LVL);

  // Fill level and almost-full registers.
  always_ff @(posedge wclk or negedge wrst_n) begin
    if (!wrst_n) begin
      wlevel_reg <= '0;
      afull_reg  <= 1'b0;
    end else begin
      wlevel_reg <= level_next;
      afull_reg  <= afull_next;
    end
  end

  assign wlevel       = wlevel_reg;
  assign walmost_full = afull_reg;
`else
  assign wlevel       = '0;
  assign walmost_full = 1'b0;
`endif

endmodule

// File: tb/tb_wptr_full.sv
// tb_wptr_full: randomized self-checking bench for wptr_full (ASIZE=4).
// The reference model tracks total words written and total words read as
// plain integers; pointers, full and level are derived from those counts.
module tb_wptr_full;
  localparam int ASZ   = 4;
  localparam int DEPTH = 1 << ASZ;
  localparam int THR   = DEPTH - 2;

  logic           wclk;
  logic           wrst_n;
  logic           winc;
  logic [ASZ:0]   wq2_rptr;
  logic           wovf_clr;
  logic [ASZ-1:0] waddr;
  logic [ASZ:0]   wptr;
  logic           wfull;
  logic           walmost_full;
  logic [ASZ:0]   wlevel;
  logic           woverflow;

  int checks = 0;
  int errors = 0;

  // model state: unbounded counts
  int  wr_total;
  int  rd_total;
  bit  m_full;
  bit  m_ovf;

  wptr_full #(.ASIZE(ASZ), .AFULL_THRESH(THR)) dut (
    .wclk(wclk), .wrst_n(wrst_n), .winc(winc), .wq2_rptr(wq2_rptr),
    .wovf_clr(wovf_clr), .waddr(waddr), .wptr(wptr), .wfull(wfull),
    .walmost_full(walmost_full), .wlevel(wlevel), .woverflow(woverflow)
  );

  initial wclk = 1'b0;
  always #5 wclk = ~wclk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [ASZ:0] to_gray(input int n);
    logic [ASZ:0] b;
    b = n[ASZ:0];
    return b ^ (b >> 1);
  endfunction

  function automatic int exp_level();
`ifdef WPTR_LEVEL_EN
    return wr_total - rd_total;
`else
    return 0;
`endif
  endfunction

  function automatic bit exp_afull();
`ifdef WPTR_LEVEL_EN
    return (wr_total - rd_total) >= THR;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check_all(input string tag);
    int wt;
    wt = wr_total;
    check({tag, ".wptr"},  32'(wptr),         32'(to_gray(wt)));
    check({tag, ".waddr"}, 32'(waddr),        32'(wt % DEPTH));
    check({tag, ".wfull"}, 32'(wfull),        32'(m_full));
    check({tag, ".wlevel"},32'(wlevel),       32'(exp_level()));
    check({tag, ".afull"}, 32'(walmost_full), 32'(exp_afull()));
    check({tag, ".ovf"},   32'(woverflow),    32'(m_ovf));
  endtask

  task automatic set_rd(input int n);
    rd_total = n;
    wq2_rptr = to_gray(n);
  endtask

  // One clock: apply inputs, advance the model, sample 1 ns after the edge.
  task automatic step(input bit inc, input bit clr, input string tag);
    bit push;
    bit ovf_n;
    winc     = inc;
    wovf_clr = clr;
    push  = inc && !m_full;
    ovf_n = (inc && m_full) || (m_ovf && !clr);
    @(posedge wclk);
    #1;
    if (push) wr_total++;
    m_full = (wr_total - rd_total) == DEPTH;
    m_ovf  = ovf_n;
    $display("step %s winc=%0b clr=%0b wr=%0d rd=%0d wptr=%0h full=%0b lvl=%0d",
             tag, inc, clr, wr_total, rd_total, wptr, wfull, wlevel);
    check_all(tag);
  endtask

  task automatic do_reset();
    wrst_n = 1'b0;
    wr_total = 0;
    rd_total = 0;
    m_full = 1'b0;
    m_ovf  = 1'b0;
    wq2_rptr = '0;
    #1;
    check_all("async_rst");
    @(posedge wclk);
    #1;
    check_all("rst_hold");
    wrst_n = 1'b1;
    winc = 1'b0;
  endtask

  initial begin
    wrst_n = 1'b1;
    winc = 1'b0;
    wovf_clr = 1'b0;
    wq2_rptr = '0;
    @(posedge wclk);
    #1;

    // reset with winc held high: nothing moves
    winc = 1'b1;
    do_reset();
    step(1'b1, 1'b0, "first_push");
    check("first_waddr", 32'(waddr), 32'd1);
    check("first_wptr", 32'(wptr), 32'h01);

    // 16 pushes from empty -> full
    @(posedge wclk);
    #1;
    do_reset();
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, 1'b0, "fill");
`ifdef WPTR_LEVEL_EN
      if (i == THR - 2) check("afull_at13", 32'(walmost_full), 32'd0);
      if (i == THR - 1) check("afull_at14", 32'(walmost_full), 32'd1);
`endif
    end
    check("full_after16", 32'(wfull), 32'd1);
    check("full_wptr", 32'(wptr), 32'h18);
    check("full_waddr", 32'(waddr), 32'd0);

    // overflow behaviour while full
    step(1'b1, 1'b0, "ovf_set");
    check("ovf_wptr_hold", 32'(wptr), 32'h18);
    check("ovf_flag", 32'(woverflow), 32'd1);
    step(1'b0, 1'b1, "ovf_clr");
    check("ovf_cleared", 32'(woverflow), 32'd0);
    step(1'b1, 1'b1, "ovf_set_clr");
    check("ovf_set_wins", 32'(woverflow), 32'd1);
    step(1'b0, 1'b1, "ovf_clr2");

    // one read frees a slot
    set_rd(1);
    step(1'b0, 1'b0, "one_read");
    check("unfull", 32'(wfull), 32'd0);
    step(1'b1, 1'b0, "refill");
    check("refull", 32'(wfull), 32'd1);

    // randomized traffic with a lagging read pointer
    for (int i = 0; i < 400; i++) begin
      if (rd_total < wr_total && $urandom_range(0, 2) == 0)
        set_rd(rd_total + int'($urandom_range(1, wr_total - rd_total)));
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 7) == 0), "rand");
    end

    // asynchronous reset mid-operation, then stream with reads trailing by 3
    #2;
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, "lead");
    for (int i = 0; i < 40; i++) begin
      set_rd(wr_total - 3);
      step(1'b1, 1'b0, "trail");
      check("trail_nofull", 32'(wfull), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
